// File: rtl/intersection_ctrl.sv
// Two-direction intersection phase scheduler: NS/EW green-yellow-allred cycle with optional walk phase.
// Walk phase, pedestrian latch and walk lamp exist only when INTERSECTION_PED_EN is defined.
module intersection_ctrl #(
    parameter int unsigned GREEN_T  = 30,
    parameter int unsigned YELLOW_T = 4,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned WALK_T   = 10,
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [7:0] count,
    output logic       tick,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    state_t        state_succ;
    logic [PW-1:0] presc;
    logic          advance;
    logic          ped_go;

    function automatic logic [7:0] dur_m1(input state_t s);
        case (s)
            NS_G, EW_G: dur_m1 = 8'(GREEN_T - 1);
            NS_Y, EW_Y: dur_m1 = 8'(YELLOW_T - 1);
            WALK:       dur_m1 = 8'(WALK_T - 1);
            default:    dur_m1 = 8'(ALLRED_T - 1);
        endcase
    endfunction

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            NS_G:    lamps_of = 6'b001_100;
            NS_Y:    lamps_of = 6'b010_100;
            EW_G:    lamps_of = 6'b100_001;
            EW_Y:    lamps_of = 6'b100_010;
            default: lamps_of = 6'b100_100;
        endcase
    endfunction

    assign tick    = (presc == PRESC_LAST);
    assign advance = tick && (count == '0);

`ifdef INTERSECTION_PED_EN
    assign ped_go = ped_pending;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_go         = 1'b0;
    assign ped_pending    = 1'b0;
    assign walk           = 1'b0;
`endif

    always_comb begin
        state_succ = NS_G;
        case (state)
            NS_G:    state_succ = NS_Y;
            NS_Y:    state_succ = AR1;
            AR1:     state_succ = EW_G;
            EW_G:    state_succ = EW_Y;
            EW_Y:    state_succ = AR2;
            AR2:     state_succ = ped_go ? WALK : NS_G;
            default: state_succ = NS_G;
        endcase
    end

    // Lamps are registered from the successor state, so they always equal a decode of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= AR2;
            count <= 8'(ALLRED_T - 1);
            presc <= '0;
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= 6'b100_100;
        end else if (advance) begin
            state <= state_succ;
            count <= dur_m1(state_succ);
            presc <= '0;
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= lamps_of(state_succ);
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) count <= count - 8'd1;
        end

`ifdef INTERSECTION_PED_EN
        if (rst) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            // A request coinciding with walk entry keeps the latch set for the next round.
            if (ped_req)
                ped_pending <= 1'b1;
            else if (advance && state_succ == WALK)
                ped_pending <= 1'b0;
            if (advance)
                walk <= (state_succ == WALK);
        end
`endif
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized self-checking bench for intersection_ctrl against a cycle-count phase model.
module tb_intersection_ctrl;

    localparam int T = 2, G = 3, Y = 2, A = 1, W = 2;
    localparam int BASE_PERIOD = (2*G + 2*Y + 2*A) * T;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic [7:0] count;
    logic       tick, ped_pending;

    int total = 0;
    int bad   = 0;

    intersection_ctrl #(
        .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(A), .WALK_T(W), .TICK_DIV(T)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .count(count), .tick(tick), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    // Phase ids: 0 NS_G, 1 NS_Y, 2 AR1, 3 EW_G, 4 EW_Y, 5 AR2, 6 WALK
    int         dur_tbl [7] = '{G, Y, A, G, Y, A, W};
    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    logic [6:0] lamp_tbl[7] = '{7'b0011000, 7'b0101000, 7'b1001000, 7'b1000010,
                                7'b1000100, 7'b1001000, 7'b1001001};

    int m_ph   = 5;
    int m_rem  = A * T;
    bit m_pend = 0;

    int since     = 0;
    bit saw_walk  = 0;
    bit per_valid = 0;
    bit prev_ng   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic p);
        bit old_pend;
        bit enter_walk;
        int nxt;
        if (r) begin
            m_ph = 5; m_rem = A * T; m_pend = 0;
            return;
        end
        old_pend   = m_pend;
        enter_walk = 0;
        m_rem--;
        if (m_rem == 0) begin
            if (m_ph == 5)      nxt = old_pend ? 6 : 0;
            else if (m_ph == 6) nxt = 0;
            else                nxt = m_ph + 1;
            enter_walk = (nxt == 6);
            m_ph  = nxt;
            m_rem = dur_tbl[nxt] * T;
        end
`ifdef INTERSECTION_PED_EN
        m_pend = p ? 1'b1 : (enter_walk ? 1'b0 : old_pend);
`else
        m_pend = 0;
`endif
    endtask

    task automatic compare_all(input logic r);
        check("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}, lamp_tbl[m_ph]);
        check("count", count, (m_rem - 1) / T);
        check("tick", tick, ((m_rem - 1) % T) == 0);
        check("ped_pending", ped_pending, m_pend);
        since++;
        if (m_ph == 6) saw_walk = 1;
        if (r) begin
            per_valid = 0;
        end else if (ns_green && !prev_ng) begin
            if (per_valid) check("period", since, BASE_PERIOD + (saw_walk ? W * T : 0));
            since = 0; saw_walk = 0; per_valid = 1;
        end
        prev_ng = ns_green;
    endtask

    task automatic step(input logic r, input logic p);
        rst = r; ped_req = p;
        @(posedge clk);
        model_step(r, p);
        #1;
        compare_all(r);
        rst = 1'b0; ped_req = 1'b0;
    endtask

    // Step idle until the model is in phase ph with remaining cycles rem (rem=0: any).
    task automatic wait_for(input int ph, input int rem, input string tag);
        int n = 0;
        while (!(m_ph == ph && (rem == 0 || m_rem == rem)) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) check(tag, 0, 1);
    endtask

    initial begin
        // Reset held, then release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);

        // Single request during NS_G
        wait_for(0, 0, "timeout_nsg1");
        step(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);

        // Request on the cycle that enters WALK
        wait_for(0, 0, "timeout_nsg2");
        step(1'b0, 1'b1);
        wait_for(5, 1, "timeout_ar2");
        step(1'b0, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0);

        // Reset mid EW_G with count=1
        wait_for(3, T + 1, "timeout_ewg");
        step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);

        // Randomized requests and occasional resets
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 249) == 0, $urandom_range(0, 11) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
